// File: rtl/addr_decode_pkg.sv
// Shared scan definitions: datapath width, scan configuration record and the
// affine address helper used by address generators and by the checker.
package addr_decode_pkg;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] offset;
        logic [W-1:0] x_max;
        logic [W-1:0] x_stride;
        logic [W-1:0] y_max;
        logic [W-1:0] y_stride;
    } scan_cfg_t;

    // Products and sums wrap modulo 2^W by truncation to the return width.
    function automatic logic [W-1:0] scan_addr(input scan_cfg_t cfg,
                                               input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        return cfg.offset + x * cfg.x_stride + y * cfg.y_stride;
    endfunction

endpackage

// File: rtl/scan_wrap_counter.sv
// One scan dimension: counts advances and wraps to zero after max-1
// (an extent of zero is treated as one).
module scan_wrap_counter #(
    parameter int unsigned W = addr_decode_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] max_i,
    input  logic         adv_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] last;

    assign last   = (max_i == '0) ? '0 : max_i - W'(1);
    assign wrap_o = adv_i && (cnt_q == last);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = (cnt_q == last) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/addr_decode.sv
// Scan-order address checker: compares each accepted address against the
// expected affine scan address and reports coordinates, match and error count.
module addr_decode #(
    parameter int unsigned W = addr_decode_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] offset,
    input  logic [W-1:0] x_stride,
    input  logic [W-1:0] y_stride,
    input  logic [W-1:0] x_max,
    input  logic [W-1:0] y_max,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_addr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y,
    output logic         out_match,
    output logic [W-1:0] err_count,
    output logic         frame_done
);

    import addr_decode_pkg::*;

    scan_cfg_t    cfg;
    logic         accept;
    logic [W-1:0] x_q, y_q;
    logic         x_wrap, y_wrap;
    logic [W-1:0] exp_addr;
    logic         hit;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_x_q, out_x_d;
    logic [W-1:0] out_y_q, out_y_d;
    logic         out_match_q, out_match_d;
    logic [W-1:0] err_count_q, err_count_d;
    logic         frame_done_q, frame_done_d;

    assign cfg = '{offset: offset, x_max: x_max, x_stride: x_stride,
                   y_max: y_max, y_stride: y_stride};

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !rst;

    scan_wrap_counter #(.W(W)) u_x_cnt (
        .clk    (clk),
        .rst    (rst),
        .max_i  (cfg.x_max),
        .adv_i  (accept),
        .cnt_o  (x_q),
        .wrap_o (x_wrap)
    );

    // y only moves when x wraps, so y_wrap already implies the frame's last beat.
    scan_wrap_counter #(.W(W)) u_y_cnt (
        .clk    (clk),
        .rst    (rst),
        .max_i  (cfg.y_max),
        .adv_i  (x_wrap),
        .cnt_o  (y_q),
        .wrap_o (y_wrap)
    );

    assign exp_addr = scan_addr(cfg, x_q, y_q);
    assign hit      = (in_addr == exp_addr);

    always_comb begin
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_match_d  = out_match_q;
        err_count_d  = err_count_q;
        frame_done_d = y_wrap;
        if (accept) begin
            out_valid_d = 1'b1;
            out_x_d     = x_q;
            out_y_d     = y_q;
            out_match_d = hit;
            if (!hit && (err_count_q != '1)) begin
                err_count_d = err_count_q + W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Result register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_match_q  <= 1'b0;
            err_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_match_q  <= out_match_d;
            err_count_q  <= err_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_match  = out_match_q;
    assign err_count  = err_count_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_addr_decode.sv
// Directed bench for addr_decode with an independent scan model and an
// expected-result queue compared whenever the DUT holds a result.
module tb_addr_decode;

    logic        clk;
    logic        rst;
    logic [31:0] offset, x_stride, y_stride, x_max, y_max;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x, out_y;
    logic        out_match;
    logic [31:0] err_count;
    logic        frame_done;

    addr_decode #(.W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .offset     (offset),
        .x_stride   (x_stride),
        .y_stride   (y_stride),
        .x_max      (x_max),
        .y_max      (y_max),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_match  (out_match),
        .err_count  (err_count),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        m;
    } exp_t;

    exp_t        sb[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] mx, my, m_err;
    logic        m_valid, m_frame;
    int          frames_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        sb.delete();
        mx = '0; my = '0; m_err = '0;
        m_valid = 1'b0; m_frame = 1'b0;
    endtask

    // One clock: drive at negedge, check visible state, update model, pass posedge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic r, input logic rs);
        logic        exp_ready, acc, last;
        logic [31:0] xm, ym, ea;
        exp_t        e;
        @(negedge clk);
        in_valid = v; in_addr = a; out_ready = r; rst = rs;
        #1;
        exp_ready = !m_valid || r;
        if (!rs) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("frame_done", {31'd0, frame_done}, {31'd0, m_frame});
            chk("err_count", err_count, m_err);
            if (frame_done === 1'b1) frames_seen++;
            if (m_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb[0];
                    chk("out_x", out_x, e.x);
                    chk("out_y", out_y, e.y);
                    chk("out_match", {31'd0, out_match}, {31'd0, e.m});
                    if (r) void'(sb.pop_front());
                end
            end
        end
        acc = v && exp_ready && !rs;
        if (rs) begin
            model_reset();
        end else begin
            xm = (x_max == 0) ? 32'd1 : x_max;
            ym = (y_max == 0) ? 32'd1 : y_max;
            last = (mx == xm - 1) && (my == ym - 1);
            m_frame = acc && last;
            if (acc) begin
                ea = offset + mx * x_stride + my * y_stride;
                e.x = mx; e.y = my; e.m = (a == ea);
                sb.push_back(e);
                if (!e.m && m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
                if (mx == xm - 1) begin
                    mx = 0;
                    my = (my == ym - 1) ? 32'd0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
            m_valid = acc ? 1'b1 : (r ? 1'b0 : m_valid);
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        cycle(1'b1, 32'd0, 1'b1, 1'b1);
        cycle(1'b1, 32'd0, 1'b1, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("sb_empty", sb.size(), 32'd0);
    endtask

    task automatic cfg_a();
        offset = 32'd100; x_max = 32'd3; x_stride = 32'd4; y_max = 32'd2; y_stride = 32'd16;
    endtask

    initial begin
        logic [31:0] seq_ok [6];
        logic [31:0] seq_bad[6];
        seq_ok  = '{32'd100, 32'd104, 32'd108, 32'd116, 32'd120, 32'd124};
        seq_bad = '{32'd100, 32'd104, 32'd109, 32'd116, 32'd120, 32'd124};
        in_valid = 0; in_addr = 0; out_ready = 1; rst = 1;
        model_reset();
        cfg_a();

        // Reset state
        do_reset();
        @(negedge clk); #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_x", out_x, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_out_match", {31'd0, out_match}, 32'd0);
        chk("rst_err", err_count, 32'd0);
        chk("rst_frame", {31'd0, frame_done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Clean frame
        frames_seen = 0;
        for (int i = 0; i < 6; i++) cycle(1'b1, seq_ok[i], 1'b1, 1'b0);
        drain();
        chk("frame_once", frames_seen, 32'd1);
        chk("clean_err", err_count, 32'd0);

        // One corrupted beat
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, seq_bad[i], 1'b1, 1'b0);
        drain();
        chk("bad_err", err_count, 32'd1);

        // Back-pressure: held result, then release
        do_reset();
        cycle(1'b1, 32'd100, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'd104, 1'b0, 1'b0);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        cycle(1'b1, 32'd104, 1'b1, 1'b0);
        cycle(1'b1, 32'd108, 1'b1, 1'b0);
        drain();
        chk("hold_err", err_count, 32'd0);

        // Degenerate 1x1 frame
        offset = 32'd7; x_max = 32'd0; y_max = 32'd0;
        do_reset();
        frames_seen = 0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'd7, 1'b1, 1'b0);
        drain();
        chk("frame_every", frames_seen, 32'd4);

        // Reset mid-frame
        cfg_a();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, seq_bad[i], 1'b1, 1'b0);
        cycle(1'b1, 32'd100, 1'b1, 1'b1);
        @(negedge clk); #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_err", err_count, 32'd0);
        cycle(1'b1, 32'd100, 1'b1, 1'b0);
        drain();

        // Stride wrap modulo 2^32
        offset = 32'd0; x_max = 32'd2; x_stride = 32'hFFFF_FFFF; y_max = 32'd1; y_stride = 32'd0;
        do_reset();
        cycle(1'b1, 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drain();
        chk("wrap_err", err_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/addr_decode.md
ADDR_DECODE -- requirements
Module: addr_decode

Interface
REQ-001 Parameter W, default 32: datapath width of addresses, strides, coordinates and counters.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 offset, x_stride, y_stride  input  W each  affine address parameters; quasi-static.
REQ-005 x_max, y_max  input  W each  scan extents; quasi-static.
REQ-006 in_valid  input  1  in_addr holds an address beat.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 in_addr  input  W  address under check.
REQ-009 out_valid  output  1  result register holds a beat.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out_x, out_y  output  W each  expected scan coordinates of the checked beat.
REQ-012 out_match  output  1  1 when in_addr equalled the expected address.
REQ-013 err_count  output  W  number of mismatching beats, saturating.
REQ-014 frame_done  output  1  one-cycle pulse marking acceptance of the last beat of a frame.

Function
REQ-015 Internal counters x, y track the expected scan order: x innermost, y outer, both starting at 0.
REQ-016 A beat is accepted when in_valid and in_ready are both 1; only acceptance advances state.
REQ-017 Expected address = offset + x*x_stride + y*y_stride, computed modulo 2^W (products and sums truncated to W bits).
REQ-018 On acceptance, x advances to x+1, or to 0 when x = xm-1; y advances only when x wraps, to y+1, or to 0 when y = ym-1.
REQ-019 xm = x_max, except xm = 1 when x_max = 0; ym is defined likewise from y_max; no division or modulo is used.
REQ-020 in_ready = !out_valid || out_ready (single-entry skid-free output register; full throughput).
REQ-021 Latency: the result of a beat accepted in cycle N appears with out_valid=1 in cycle N+1.
REQ-022 out_x, out_y, and out_match shall hold stable while out_valid=1 and out_ready=0.
REQ-023 out_valid clears after a cycle with out_ready=1, unless a new beat is accepted in that same cycle.
REQ-024 err_count increments by 1 in the cycle after a mismatching beat is accepted, and holds at 2^W-1.
REQ-025 frame_done pulses in the cycle after acceptance of the beat with x = xm-1 and y = ym-1, independent of out_ready.
REQ-026 Simultaneous output drain and new acceptance: the register is reloaded with no bubble.

Reset
REQ-027 When rst=1, x, y, out_x, out_y, err_count = 0, and out_valid, out_match, frame_done = 0.
REQ-028 Reset mid-operation discards any held result and restarts expectation at (0,0); in_ready = 1 in the cycle following reset.
REQ-029 A beat presented during a reset cycle is not accepted.

Structure
REQ-030 A shared package defines W and a scan-config struct (offset, x_max, x_stride, y_max, y_stride), which is reused by address generators and the checker.
REQ-031 The wrap counter (count, max, advance, wrap-out) is one sub-module, scan_wrap_counter, instantiated twice with the x wrap output chained to the y advance input.
REQ-032 Expected-address arithmetic is combinational from the registered x and y values; there is no extra pipeline stage.

Verification
REQ-033 offset=100, x_max=3, x_stride=4, y_max=2, y_stride=16; feed 100,104,108,116,120,124 with out_ready=1 -> out_match=1 on all six, coords (0,0)..(2,1), frame_done pulses once after the 6th beat, err_count=0.
REQ-034 Same config, third beat 109 -> out_match=0 for that beat only, err_count=1, and the following beats still match (counters advance regardless).
REQ-035 out_ready=0 for 3 cycles while in_valid=1 -> exactly one beat accepted, in_ready=0 while held, outputs stable, and no beat is lost or duplicated on release.
REQ-036 x_max=0, y_max=0, offset=7: repeated in_addr=7 -> every beat matches at (0,0), and frame_done pulses on every beat.
REQ-037 rst asserted after 4 of 6 beats -> out_valid=0 and err_count=0 next cycle, and the next accepted beat is checked against offset (coords 0,0).
REQ-038 x_stride=0xFFFFFFFF, x_max=2, offset=0: beats 0, 0xFFFFFFFF -> both match (wrap modulo 2^32).
